// File: rtl/mem_access_pkg.sv
// Shared encodings and helpers for the data-RAM access unit: funct3 width codes,
// FSM states, access-size and funct3-legality lookups.
package mem_access_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    RESP
  } state_t;

  // Bytes touched by an access; illegal codes fall back to 4, which is harmless
  // because they are rejected before any strobe or read is used.
  function automatic logic [2:0] access_size(input logic [2:0] funct3);
    case (funct3)
      F3_B, F3_BU: return 3'd1;
      F3_H, F3_HU: return 3'd2;
      default:     return 3'd4;
    endcase
  endfunction

  function automatic logic funct3_legal(input logic store, input logic [2:0] funct3);
    if (store) return funct3 inside {F3_B, F3_H, F3_W};
    else       return funct3 inside {F3_B, F3_H, F3_W, F3_BU, F3_HU};
  endfunction

endpackage

// File: rtl/mem_access_unit_load_extend.sv
// Sign/zero extension of the raw little-endian RAM read word according to the
// load funct3 code.
module load_extend
  import mem_access_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic [2:0]       funct3,
  input  logic [WIDTH-1:0] raw,
  output logic [WIDTH-1:0] ext
);

  // NOTE: ext gets a default before the case so every path assigns it and no latch is inferred.
  always_comb begin
    ext = raw;
    case (funct3)
      F3_B:    ext = {{(WIDTH-8){raw[7]}}, raw[7:0]};
      F3_BU:   ext = {{(WIDTH-8){1'b0}}, raw[7:0]};
      F3_H:    ext = {{(WIDTH-16){raw[15]}}, raw[15:0]};
      F3_HU:   ext = {{(WIDTH-16){1'b0}}, raw[15:0]};
      default: ext = raw;
    endcase
  end

endmodule

// File: rtl/mem_access_unit.sv
// Initiator-side controller for the byte-addressable data RAM: one load/store at a
// time, IDLE -> ACCESS -> RESP, single-cycle store strobes, registered load response.
module mem_access_unit
  import mem_access_pkg::*;
#(
  parameter int                        ADDRESS_LENGTH = 32,
  parameter logic [ADDRESS_LENGTH-1:0] DATA_BASE      = 32'h0000_1000,
  parameter logic [ADDRESS_LENGTH-1:0] DATA_TOP       = 32'h0000_1FFF
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      req_valid,
  output logic                      req_ready,
  input  logic                      req_store,
  input  logic [2:0]                req_funct3,
  input  logic [ADDRESS_LENGTH-1:0] req_addr,
  input  logic [ADDRESS_LENGTH-1:0] req_wdata,
  output logic                      resp_valid,
  input  logic                      resp_ready,
  output logic [ADDRESS_LENGTH-1:0] resp_rdata,
  output logic                      resp_err,
  output logic [ADDRESS_LENGTH-1:0] mem_a,
  output logic [ADDRESS_LENGTH-1:0] mem_wd,
  output logic                      mem_sb,
  output logic                      mem_sh,
  output logic                      mem_sw,
  input  logic [ADDRESS_LENGTH-1:0] mem_rd
);

  state_t     state;
  logic       store_q;
  logic [2:0] funct3_q;
  logic       err_q;

  logic [ADDRESS_LENGTH:0]   last_byte;
  logic                      in_range;
  logic                      req_legal;
  logic [ADDRESS_LENGTH-1:0] load_data;

  // One extra bit so an access running past the top of the address space
  // compares as out of range instead of wrapping to a small address.
  assign last_byte = {1'b0, req_addr}
                   + {{(ADDRESS_LENGTH-2){1'b0}}, access_size(req_funct3)}
                   - {{ADDRESS_LENGTH{1'b0}}, 1'b1};
  assign in_range  = (req_addr >= DATA_BASE) && (last_byte <= {1'b0, DATA_TOP});
  assign req_legal = in_range && funct3_legal(req_store, req_funct3);

  load_extend #(.WIDTH(ADDRESS_LENGTH)) u_load_extend (
    .funct3 (funct3_q),
    .raw    (mem_rd),
    .ext    (load_data)
  );

  // NOTE: all state and outputs use non-blocking assignments so every register
  // samples pre-edge values, independent of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      req_ready  <= 1'b1;
      resp_valid <= 1'b0;
      resp_rdata <= '0;
      resp_err   <= 1'b0;
      mem_a      <= '0;
      mem_wd     <= '0;
      mem_sb     <= 1'b0;
      mem_sh     <= 1'b0;
      mem_sw     <= 1'b0;
      store_q    <= 1'b0;
      funct3_q   <= '0;
      err_q      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (req_valid && req_ready) begin
            store_q   <= req_store;
            funct3_q  <= req_funct3;
            mem_a     <= req_addr;
            mem_wd    <= req_wdata;
            err_q     <= !req_legal;
            // Strobes are raised here so they are high for exactly the ACCESS cycle.
            mem_sb    <= req_store && req_legal && (req_funct3 == F3_B);
            mem_sh    <= req_store && req_legal && (req_funct3 == F3_H);
            mem_sw    <= req_store && req_legal && (req_funct3 == F3_W);
            req_ready <= 1'b0;
            state     <= ACCESS;
          end
        end
        ACCESS: begin
          mem_sb     <= 1'b0;
          mem_sh     <= 1'b0;
          mem_sw     <= 1'b0;
          resp_rdata <= (!store_q && !err_q) ? load_data : '0;
          resp_err   <= err_q;
          resp_valid <= 1'b1;
          state      <= RESP;
        end
        RESP: begin
          if (resp_ready) begin
            resp_valid <= 1'b0;
            req_ready  <= 1'b1;
            state      <= IDLE;
          end
        end
        default: begin
          resp_valid <= 1'b0;
          req_ready  <= 1'b1;
          state      <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit with a byte-array data RAM model covering
// 0x1000..0x1FFF; each scenario task compares against hand-computed values.
module tb_mem_access_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid, req_ready, req_store;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr, req_wdata;
  logic        resp_valid, resp_ready, resp_err;
  logic [31:0] resp_rdata, mem_a, mem_wd, mem_rd;
  logic        mem_sb, mem_sh, mem_sw;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mem_access_unit dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_store  (req_store),
    .req_funct3 (req_funct3),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .resp_valid (resp_valid),
    .resp_ready (resp_ready),
    .resp_rdata (resp_rdata),
    .resp_err   (resp_err),
    .mem_a      (mem_a),
    .mem_wd     (mem_wd),
    .mem_sb     (mem_sb),
    .mem_sh     (mem_sh),
    .mem_sw     (mem_sw),
    .mem_rd     (mem_rd)
  );

  // RAM model: bytes outside 0x1000..0x1FFF read as zero and ignore writes.
  logic [7:0] ram [0:4095];
  logic       ram_init = 1'b0;
  int         sb_cnt = 0, sh_cnt = 0, sw_cnt = 0, multi_cnt = 0;

  function automatic logic [7:0] rbyte(input logic [31:0] a);
    if (a >= 32'h1000 && a <= 32'h1FFF) return ram[a[11:0]];
    return 8'h00;
  endfunction

  always_comb mem_rd = {rbyte(mem_a + 32'd3), rbyte(mem_a + 32'd2),
                        rbyte(mem_a + 32'd1), rbyte(mem_a)};

  always @(posedge clk) begin
    logic [31:0] a;
    if (!ram_init) begin
      for (int i = 0; i < 4096; i++) ram[i] <= 8'(i) ^ 8'h5A;
      ram_init <= 1'b1;
    end else begin
      for (int i = 0; i < 4; i++) begin
        a = mem_a + 32'(i);
        if ((mem_sw || (mem_sh && i < 2) || (mem_sb && i == 0)) &&
            a >= 32'h1000 && a <= 32'h1FFF)
          ram[a[11:0]] <= mem_wd[8*i +: 8];
      end
    end
    if (mem_sb) sb_cnt <= sb_cnt + 1;
    if (mem_sh) sh_cnt <= sh_cnt + 1;
    if (mem_sw) sw_cnt <= sw_cnt + 1;
    if (32'(mem_sb) + 32'(mem_sh) + 32'(mem_sw) > 1) multi_cnt <= multi_cnt + 1;
  end

  // Runs one full transaction with resp_ready asserted as soon as the response
  // appears; lat counts negedges after the handshake edge until resp_valid.
  task automatic issue(input logic st, input logic [2:0] f3, input logic [31:0] a,
                       input logic [31:0] wd, output logic [2:0] stb,
                       output logic [31:0] a_seen, output logic [31:0] rdata,
                       output logic err, output int lat);
    @(negedge clk);
    req_valid = 1'b1; req_store = st; req_funct3 = f3; req_addr = a; req_wdata = wd;
    resp_ready = 1'b0;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    stb = {mem_sb, mem_sh, mem_sw};
    a_seen = mem_a;
    lat = 1;
    while (!resp_valid && lat < 10) begin
      @(negedge clk);
      lat++;
    end
    rdata = resp_rdata;
    err = resp_err;
    resp_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    resp_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; req_valid = 1'b0; req_store = 1'b0; req_funct3 = 3'b0;
    req_addr = '0; req_wdata = '0; resp_ready = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if ({req_ready, resp_valid, resp_err} !== 3'b100) begin
      errors++; $display("FAIL reset_hs: got %b expected 100", {req_ready, resp_valid, resp_err});
    end
    checks++;
    if ({mem_sb, mem_sh, mem_sw} !== 3'b000) begin
      errors++; $display("FAIL reset_strobes: got %b expected 000", {mem_sb, mem_sh, mem_sw});
    end
    checks++;
    if ({resp_rdata, mem_a, mem_wd} !== 96'h0) begin
      errors++; $display("FAIL reset_data: got %h expected 0", {resp_rdata, mem_a, mem_wd});
    end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_store_load();
    logic [2:0] stb; logic [31:0] as, rd; logic er; int lat, sw0;
    sw0 = sw_cnt;
    issue(1'b1, 3'b010, 32'h1000, 32'hDEADBEEF, stb, as, rd, er, lat);
    checks++;
    if (stb !== 3'b001 || as !== 32'h1000) begin
      errors++; $display("FAIL sw_access: strobes %b addr %h expected 001 00001000", stb, as);
    end
    checks++;
    if (sw_cnt - sw0 !== 1) begin
      errors++; $display("FAIL sw_once: got %0d cycles expected 1", sw_cnt - sw0);
    end
    checks++;
    if ({er, rd} !== 33'h0 || lat !== 2) begin
      errors++; $display("FAIL sw_resp: err %b rdata %h lat %0d expected 0 0 2", er, rd, lat);
    end
    issue(1'b0, 3'b010, 32'h1000, 32'h0, stb, as, rd, er, lat);
    checks++;
    if (rd !== 32'hDEADBEEF || er !== 1'b0 || lat !== 2) begin
      errors++; $display("FAIL lw_resp: rdata %h err %b lat %0d expected deadbeef 0 2", rd, er, lat);
    end
  endtask

  task automatic test_extend();
    logic [2:0] f3_t [4]; logic [31:0] a_t [4]; logic [31:0] exp_t [4];
    logic [2:0] stb; logic [31:0] as, rd; logic er; int lat;
    f3_t[0] = 3'b000; a_t[0] = 32'h1000; exp_t[0] = 32'hFFFFFFEF;
    f3_t[1] = 3'b100; a_t[1] = 32'h1000; exp_t[1] = 32'h000000EF;
    f3_t[2] = 3'b001; a_t[2] = 32'h1002; exp_t[2] = 32'hFFFFDEAD;
    f3_t[3] = 3'b101; a_t[3] = 32'h1002; exp_t[3] = 32'h0000DEAD;
    for (int i = 0; i < 4; i++) begin
      issue(1'b0, f3_t[i], a_t[i], 32'h0, stb, as, rd, er, lat);
      checks++;
      if (rd !== exp_t[i] || er !== 1'b0) begin
        errors++; $display("FAIL extend_%0d: rdata %h err %b expected %h 0", i, rd, er, exp_t[i]);
      end
    end
  endtask

  task automatic test_byte_store();
    logic [2:0] stb; logic [31:0] as, rd; logic er; int lat, b0, h0, w0;
    b0 = sb_cnt; h0 = sh_cnt; w0 = sw_cnt;
    issue(1'b1, 3'b000, 32'h1001, 32'h12345678, stb, as, rd, er, lat);
    checks++;
    if (stb !== 3'b100) begin
      errors++; $display("FAIL sb_access: strobes %b expected 100", stb);
    end
    issue(1'b0, 3'b010, 32'h1000, 32'h0, stb, as, rd, er, lat);
    checks++;
    if (rd !== 32'hDEAD78EF) begin
      errors++; $display("FAIL sb_readback: got %h expected dead78ef", rd);
    end
    checks++;
    if (sb_cnt - b0 !== 1 || sh_cnt - h0 !== 0 || sw_cnt - w0 !== 0) begin
      errors++; $display("FAIL sb_only: sb %0d sh %0d sw %0d expected 1 0 0",
                         sb_cnt - b0, sh_cnt - h0, sw_cnt - w0);
    end
  endtask

  task automatic test_errors();
    logic st_t [6]; logic [2:0] f3_t [6]; logic [31:0] a_t [6];
    logic err_t [6]; logic [2:0] stb_t [6];
    logic [2:0] stb; logic [31:0] as, rd; logic er; int lat, b0, h0, w0;
    st_t[0] = 1'b1; f3_t[0] = 3'b010; a_t[0] = 32'h1FFD;     err_t[0] = 1'b1; stb_t[0] = 3'b000;
    st_t[1] = 1'b0; f3_t[1] = 3'b010; a_t[1] = 32'h0FFF;     err_t[1] = 1'b1; stb_t[1] = 3'b000;
    st_t[2] = 1'b0; f3_t[2] = 3'b010; a_t[2] = 32'hFFFFFFFE; err_t[2] = 1'b1; stb_t[2] = 3'b000;
    st_t[3] = 1'b0; f3_t[3] = 3'b011; a_t[3] = 32'h1000;     err_t[3] = 1'b1; stb_t[3] = 3'b000;
    st_t[4] = 1'b1; f3_t[4] = 3'b100; a_t[4] = 32'h1000;     err_t[4] = 1'b1; stb_t[4] = 3'b000;
    st_t[5] = 1'b1; f3_t[5] = 3'b001; a_t[5] = 32'h1FFE;     err_t[5] = 1'b0; stb_t[5] = 3'b010;
    b0 = sb_cnt; h0 = sh_cnt; w0 = sw_cnt;
    for (int i = 0; i < 6; i++) begin
      issue(st_t[i], f3_t[i], a_t[i], 32'hA5A5A5A5, stb, as, rd, er, lat);
      checks++;
      if (er !== err_t[i] || rd !== 32'h0 || stb !== stb_t[i]) begin
        errors++; $display("FAIL err_case_%0d: err %b rdata %h strobes %b expected %b 00000000 %b",
                           i, er, rd, stb, err_t[i], stb_t[i]);
      end
    end
    checks++;
    if (sb_cnt - b0 !== 0 || sh_cnt - h0 !== 1 || sw_cnt - w0 !== 0) begin
      errors++; $display("FAIL err_strobes: sb %0d sh %0d sw %0d expected 0 1 0",
                         sb_cnt - b0, sh_cnt - h0, sw_cnt - w0);
    end
  endtask

  task automatic test_backpressure();
    int lat;
    @(negedge clk);
    req_valid = 1'b1; req_store = 1'b0; req_funct3 = 3'b010; req_addr = 32'h1000;
    resp_ready = 1'b0;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    lat = 1;
    while (!resp_valid && lat < 10) begin
      @(negedge clk);
      lat++;
    end
    for (int c = 0; c < 5; c++) begin
      checks++;
      if ({resp_valid, req_ready, resp_err, resp_rdata} !== {3'b100, 32'hDEAD78EF}) begin
        errors++; $display("FAIL bp_hold_%0d: valid %b ready %b err %b rdata %h expected 1 0 0 dead78ef",
                           c, resp_valid, req_ready, resp_err, resp_rdata);
      end
      @(negedge clk);
    end
    resp_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    resp_ready = 1'b0;
    checks++;
    if ({req_ready, resp_valid} !== 2'b10) begin
      errors++; $display("FAIL bp_release: ready %b valid %b expected 1 0", req_ready, resp_valid);
    end
    req_valid = 1'b1; req_store = 1'b0; req_funct3 = 3'b100; req_addr = 32'h1003;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    checks++;
    if (req_ready !== 1'b0 || mem_a !== 32'h1003) begin
      errors++; $display("FAIL bp_next_accept: ready %b addr %h expected 0 00001003", req_ready, mem_a);
    end
    lat = 1;
    while (!resp_valid && lat < 10) begin
      @(negedge clk);
      lat++;
    end
    checks++;
    if (resp_rdata !== 32'h000000DE || lat !== 2) begin
      errors++; $display("FAIL bp_next_data: rdata %h lat %0d expected 000000de 2", resp_rdata, lat);
    end
    resp_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    resp_ready = 1'b0;
  endtask

  task automatic test_reset_mid_store();
    logic [2:0] stb; logic [31:0] as, rd; logic er; int lat;
    @(negedge clk);
    req_valid = 1'b1; req_store = 1'b1; req_funct3 = 3'b010;
    req_addr = 32'h1004; req_wdata = 32'hCAFEF00D;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    checks++;
    if (mem_sw !== 1'b1) begin
      errors++; $display("FAIL rst_mid_pre: mem_sw %b expected 1", mem_sw);
    end
    #1 rst_n = 1'b0;
    #1;
    checks++;
    if ({mem_sb, mem_sh, mem_sw, resp_valid, req_ready} !== 5'b00001) begin
      errors++; $display("FAIL rst_mid_async: sb/sh/sw/valid/ready %b expected 00001",
                         {mem_sb, mem_sh, mem_sw, resp_valid, req_ready});
    end
    @(posedge clk);
    @(negedge clk);
    checks++;
    if ({ram[12'h007], ram[12'h006], ram[12'h005], ram[12'h004]} !== 32'h5D5C5F5E) begin
      errors++; $display("FAIL rst_mid_word: got %h expected 5d5c5f5e",
                         {ram[12'h007], ram[12'h006], ram[12'h005], ram[12'h004]});
    end
    rst_n = 1'b1;
    issue(1'b0, 3'b010, 32'h1004, 32'h0, stb, as, rd, er, lat);
    checks++;
    if (rd !== 32'h5D5C5F5E || er !== 1'b0 || lat !== 2) begin
      errors++; $display("FAIL rst_mid_reload: rdata %h err %b lat %0d expected 5d5c5f5e 0 2", rd, er, lat);
    end
  endtask

  initial begin
    test_reset();
    test_store_load();
    test_extend();
    test_byte_store();
    test_errors();
    test_backpressure();
    test_reset_mid_store();
    checks++;
    if (multi_cnt !== 0) begin
      errors++; $display("FAIL strobe_onehot: %0d multi-hot cycles expected 0", multi_cnt);
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_access_unit.md
Name: mem_access_unit

Overview:
- Initiator-side controller for the byte-addressable data RAM.
- Accepts one load or store request at a time from the pipeline over a valid/ready handshake.
- For stores, drives the RAM's address, write-data and single-hot store strobes (byte, half, word) for exactly one cycle.
- For loads, samples the RAM's combinational 32-bit read word, sign- or zero-extends it per funct3, and returns a registered response with valid/ready handshake and error flag.

Parameters:
- ADDRESS_LENGTH, 32, width of address and data words
- DATA_BASE, 32'h0000_1000, lowest legal data-RAM byte address
- DATA_TOP, 32'h0000_1FFF, highest legal data-RAM byte address

Ports:
- clk  input  1  system clock, rising edge
- rst_n  input  1  reset, asynchronous, active-low
- req_valid  input  1  request present
- req_ready  output  1  unit can accept request
- req_store  input  1  1 = store, 0 = load
- req_funct3  input  3  RISC-V width/sign code
- req_addr  input  ADDRESS_LENGTH  byte address
- req_wdata  input  ADDRESS_LENGTH  store data, right-aligned
- resp_valid  output  1  response present
- resp_ready  input  1  consumer accepts response
- resp_rdata  output  ADDRESS_LENGTH  extended load data; 0 for stores and errors
- resp_err  output  1  illegal funct3 or out-of-range access
- mem_a  output  ADDRESS_LENGTH  RAM byte address
- mem_wd  output  ADDRESS_LENGTH  RAM write data
- mem_sb  output  1  RAM byte-store strobe
- mem_sh  output  1  RAM half-store strobe
- mem_sw  output  1  RAM word-store strobe
- mem_rd  input  ADDRESS_LENGTH  RAM combinational read word, little-endian from mem_a

Behaviour:
- Reset values while rst_n is low, effective immediately (asynchronous):
  - state IDLE; req_ready=1; resp_valid=0; resp_rdata=0; resp_err=0.
  - mem_sb, mem_sh, mem_sw all 0; mem_a=0; mem_wd=0.
- Reset asserted mid-operation:
  - Strobes drop at once; no write occurs at the next edge.
  - Any pending response is discarded.
- State machine: IDLE -> ACCESS -> RESP -> IDLE.
- IDLE:
  - req_ready=1.
  - On req_valid&req_ready: latch store, funct3, addr and wdata into internal registers; go to ACCESS.
- ACCESS (exactly 1 cycle):
  - req_ready=0.
  - mem_a and mem_wd are driven from the latched registers.
  - Legal store: exactly one strobe is high for this cycle only (SB->mem_sb, SH->mem_sh, SW->mem_sw). The RAM commits the write on the rising edge that ends ACCESS.
  - Legal load: register extended mem_rd into resp_rdata.
  - Go to RESP.
- RESP:
  - resp_valid=1; resp_rdata and resp_err are stable.
  - Hold until resp_ready=1, then go to IDLE.
  - resp_valid=1 with resp_ready=1 on the same edge returns to IDLE. A new request can be accepted on the following cycle (no same-cycle overlap).
- Latency: handshake at edge N; ACCESS during cycle N+1; resp_valid high from edge N+2. Minimum initiation interval is 3 cycles.
- funct3 legality:
  - Load: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU.
  - Store: 000 SB, 001 SH, 010 SW.
  - All other codes: resp_err=1, resp_rdata=0, no strobe.
- Range check: access size S = 1, 2 or 4 bytes.
  - Legal iff addr >= DATA_BASE and addr+S-1 <= DATA_TOP.
  - Compute in ADDRESS_LENGTH+1 bits so wrap-around past 32'hFFFF_FFFF is treated as out of range.
  - Out of range: resp_err=1, resp_rdata=0, no strobe.
- Alignment: the RAM is byte-addressable, so misaligned legal accesses are allowed and not flagged.
- Extension, applied to mem_rd:
  - LB: sign-extend bits [7:0]; LBU: zero-extend bits [7:0].
  - LH: sign-extend bits [15:0]; LHU: zero-extend bits [15:0].
  - LW: full 32 bits.
- Store data to the RAM is passed unmodified; the RAM selects the low bytes.
- Stores return resp_rdata=0 and resp_err=0 when legal.
- Strobes are never high outside ACCESS. At most one strobe is high at any time.

Decomposition:
- Package mem_access_pkg:
  - funct3 localparams F3_B, F3_H, F3_W, F3_BU, F3_HU.
  - State enum {IDLE, ACCESS, RESP}.
  - Function returning access size from funct3.
- One combinational sub-module, load_extend: inputs funct3 and 32-bit raw word; output extended 32-bit word. Instantiated once.

Test Plan:
- Reset then SW: addr 32'h1000, wdata 32'hDEADBEEF -> mem_sw high exactly one cycle, at cycle N+1. Follow-up LW at 32'h1000 -> resp_rdata 32'hDEADBEEF, resp_err=0, resp_valid at N+2.
- Byte and half sign extension: with memory bytes 1000..1003 = EF BE AD DE:
  - LB @1000 -> 32'hFFFFFFEF; LBU @1000 -> 32'h000000EF.
  - LH @1002 -> 32'hFFFFDEAD; LHU @1002 -> 32'h0000DEAD.
- SB 32'h12345678 @1001, then LW @1000 -> 32'hDEAD78EF; only mem_sb was ever asserted.
- Range and funct3 errors, each with no strobe and resp_err=1, resp_rdata=0:
  - SW @32'h1FFD (last byte 2000).
  - LW @32'h0FFF.
  - LW @32'hFFFFFFFE (wrap).
  - Load funct3=011.
  - Store funct3=100.
  - Control case: SH @1FFE is legal.
- Backpressure: hold resp_ready=0 for 5 cycles -> resp_valid, resp_rdata and resp_err stable, req_ready=0 throughout. Release -> IDLE, next request accepted on the following edge.
- Reset mid-store: drop rst_n during ACCESS of SW 32'hCAFEF00D @1004 -> strobes fall immediately, word at 1004 unchanged, resp_valid=0, req_ready=1.
